// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types for the dual-core coherence bus controller
// Contents: system sizes, word/RAM-state types, bus FSM states, request kinds,
// and a helper that aligns a word address down to its block base.
package cpu_types_pkg;

    localparam int CPUS     = 2;
    localparam int BLKWORDS = 2;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [3:0] {
        IDLE, SNOOP, MEM0, MEM1, C2C0, C2C1, WB0, WB1, IFETCH
    } bus_state_t;

    typedef enum logic [1:0] {
        REQ_WB, REQ_FETCH, REQ_UPG, REQ_IF
    } req_kind_t;

    function automatic word_t block_addr(input word_t a);
        return a & ~word_t'(BLKWORDS * 4 - 1);
    endfunction

endpackage

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - request decode and round-robin arbitration between the two cores
// Ports:
//   CLK, nRST                         clock, synchronous active-low reset
//   i_iren/i_dren/i_dwen              per-core icache read, dcache read, dcache writeback
//   i_cctrans/i_ccwrite               per-core coherence request qualifiers
//   i_blocked                         per-core: core is currently being snooped
//   i_take                            controller is idle; a valid grant is consumed
//   o_valid/o_grant/o_kind            a request exists, winning core, request kind
module bus_arbiter
    import cpu_types_pkg::*;
(
    input  logic            CLK,
    input  logic            nRST,
    input  logic [CPUS-1:0] i_iren,
    input  logic [CPUS-1:0] i_dren,
    input  logic [CPUS-1:0] i_dwen,
    input  logic [CPUS-1:0] i_cctrans,
    input  logic [CPUS-1:0] i_ccwrite,
    input  logic [CPUS-1:0] i_blocked,
    input  logic            i_take,
    output logic            o_valid,
    output logic            o_grant,
    output req_kind_t       o_kind
);

    logic            r_rr;
    logic [CPUS-1:0] w_wb;
    logic [CPUS-1:0] w_fetch;
    logic [CPUS-1:0] w_upg;
    logic [CPUS-1:0] w_dreq;
    logic [CPUS-1:0] w_ireq;

    always_comb begin
        w_wb    = i_dwen & ~i_blocked;
        w_fetch = i_cctrans & ~i_dwen & ~i_blocked;
        w_upg   = i_ccwrite & ~i_cctrans & ~i_dren & ~i_dwen & ~i_blocked;
        w_dreq  = w_wb | w_fetch | w_upg;
        w_ireq  = i_iren & ~i_blocked;
        o_valid = 1'b1;
        o_grant = r_rr;
        o_kind  = REQ_IF;
        // Any dcache request outranks any instruction fetch; rr breaks ties.
        if (|w_dreq) begin
            o_grant = w_dreq[r_rr] ? r_rr : ~r_rr;
            if (w_wb[o_grant])
                o_kind = REQ_WB;
            else if (w_fetch[o_grant])
                o_kind = REQ_FETCH;
            else
                o_kind = REQ_UPG;
        end else if (|w_ireq) begin
            o_grant = w_ireq[r_rr] ? r_rr : ~r_rr;
        end else begin
            o_valid = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST)
            r_rr <= 1'b0;
        else if (i_take && o_valid)
            r_rr <= ~o_grant;
    end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// rtl/coherence_bus_ctrl.sv - shared-bus snoop/memory controller between two cores and one RAM port
// Ports:
//   CLK, nRST                           clock, synchronous active-low reset
//   iREN/iaddr -> iwait/iload           per-core instruction fetch
//   dREN/dWEN/daddr/dstore/cctrans/ccwrite -> dwait/dload   per-core data side
//   ccwait/ccinv/ccsnoopaddr            snoop outputs (ccinv also grants upgrades)
//   ramREN/ramWEN/ramaddr/ramstore, ramload/ramstate        single-port RAM
module coherence_bus_ctrl
    import cpu_types_pkg::*;
(
    input  logic                CLK,
    input  logic                nRST,
    input  logic [CPUS-1:0]     iREN,
    input  word_t [CPUS-1:0]    iaddr,
    output logic [CPUS-1:0]     iwait,
    output word_t [CPUS-1:0]    iload,
    input  logic [CPUS-1:0]     dREN,
    input  logic [CPUS-1:0]     dWEN,
    input  word_t [CPUS-1:0]    daddr,
    input  word_t [CPUS-1:0]    dstore,
    input  logic [CPUS-1:0]     cctrans,
    input  logic [CPUS-1:0]     ccwrite,
    output logic [CPUS-1:0]     dwait,
    output word_t [CPUS-1:0]    dload,
    output logic [CPUS-1:0]     ccwait,
    output logic [CPUS-1:0]     ccinv,
    output word_t [CPUS-1:0]    ccsnoopaddr,
    output logic                ramREN,
    output logic                ramWEN,
    output word_t               ramaddr,
    output word_t               ramstore,
    input  word_t               ramload,
    input  ramstate_t           ramstate
);

    bus_state_t       r_state;
    bus_state_t       w_next;
    logic             r_req;
    req_kind_t        r_kind;
    logic [CPUS-1:0]  r_ccwait;
    logic [CPUS-1:0]  r_ccinv;
    word_t [CPUS-1:0] r_snoopaddr;

    logic             w_valid;
    logic             w_grant;
    req_kind_t        w_kind;
    logic             w_snp;
    logic             w_done;
    logic             w_idle;

    assign w_snp  = ~r_req;
    assign w_idle = (r_state == IDLE);
    // An ERROR response still retires the word; data is simply not trustworthy.
    assign w_done = (ramstate == ACCESS) || (ramstate == ERROR);

    assign ccwait      = r_ccwait;
    assign ccsnoopaddr = r_snoopaddr;

    bus_arbiter u_arb (
        .CLK       (CLK),
        .nRST      (nRST),
        .i_iren    (iREN),
        .i_dren    (dREN),
        .i_dwen    (dWEN),
        .i_cctrans (cctrans),
        .i_ccwrite (ccwrite),
        .i_blocked (r_ccwait),
        .i_take    (w_idle),
        .o_valid   (w_valid),
        .o_grant   (w_grant),
        .o_kind    (w_kind)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_req       <= 1'b0;
            r_kind      <= REQ_WB;
            r_ccwait    <= '0;
            r_ccinv     <= '0;
            r_snoopaddr <= '0;
        end else begin
            r_state <= w_next;
            if (w_idle) begin
                if (w_valid) begin
                    r_req  <= w_grant;
                    r_kind <= w_kind;
                    // Snoop toward the other core starts on the grant edge.
                    if (w_kind == REQ_FETCH || w_kind == REQ_UPG) begin
                        r_ccwait[~w_grant]    <= 1'b1;
                        r_ccinv[~w_grant]     <= ccwrite[w_grant];
                        r_snoopaddr[~w_grant] <= block_addr(daddr[w_grant]);
                    end
                end
            end else if (w_next == IDLE) begin
                r_ccwait <= '0;
                r_ccinv  <= '0;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        iwait    = '1;
        dwait    = '1;
        iload    = '0;
        dload    = '0;
        ccinv    = r_ccinv;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (r_state)
            IDLE: begin
                if (w_valid) begin
                    case (w_kind)
                        REQ_WB:  w_next = WB0;
                        REQ_IF:  w_next = IFETCH;
                        default: w_next = SNOOP;
                    endcase
                end
            end
            SNOOP: begin
                if (r_kind == REQ_UPG) begin
                    // Upgrade needs no data: the invalidate itself is the grant.
                    ccinv[r_req] = 1'b1;
                    w_next       = IDLE;
                end else if (ccwrite[w_snp] && cctrans[w_snp]) begin
                    w_next = C2C0;
                end else begin
                    w_next = MEM0;
                end
            end
            MEM0, MEM1: begin
                ramREN  = 1'b1;
                ramaddr = daddr[r_req];
                if (w_done) begin
                    dwait[r_req] = 1'b0;
                    dload[r_req] = ramload;
                    w_next       = (r_state == MEM0) ? MEM1 : IDLE;
                end
            end
            C2C0, C2C1: begin
                // Snooper's Modified word goes to the requester and back to RAM at once.
                ramWEN       = 1'b1;
                ramaddr      = daddr[w_snp];
                ramstore     = dstore[w_snp];
                dload[r_req] = dstore[w_snp];
                if (w_done) begin
                    dwait[r_req] = 1'b0;
                    dwait[w_snp] = 1'b0;
                    w_next       = (r_state == C2C0) ? C2C1 : IDLE;
                end
            end
            WB0, WB1: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[r_req];
                ramstore = dstore[r_req];
                if (w_done) begin
                    dwait[r_req] = 1'b0;
                    w_next       = (r_state == WB0) ? WB1 : IDLE;
                end
            end
            IFETCH: begin
                ramREN  = 1'b1;
                ramaddr = iaddr[r_req];
                if (w_done) begin
                    iwait[r_req] = 1'b0;
                    iload[r_req] = ramload;
                    w_next       = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

endmodule
